// File: rtl/mem_forward_stage_pkg.sv
// Shared types for the memory stage: access sizes, slot states and the
// forwarding packet published to the hazard unit.
package mem_forward_stage_pkg;

  localparam int MEM_XLEN  = 64;
  localparam int MEM_BYTES = MEM_XLEN / 8;

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic                valid;
    creg_addr_t          dst;
    logic [MEM_XLEN-1:0] data;
  } forward_data_out;

  typedef enum logic [1:0] {
    MSIZE_B,
    MSIZE_H,
    MSIZE_W,
    MSIZE_D
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    DRAIN
  } mem_state_t;

  // Address offset not a multiple of the access size.
  function automatic logic misaligned(
    input logic [2:0] off,
    input logic [1:0] sz
  );
    logic [2:0] m;
    m = (3'd1 << sz) - 3'd1;
    return (off & m) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic: store data shift + strobe, load extract + extend.
// Ports: i_off/i_size/i_wdata/i_rdata in; o_wdata/o_strobe/o_rdata out.
module mem_lane_align
  import mem_forward_stage_pkg::*;
(
  input  logic [2:0]          i_off,
  input  logic [2:0]          i_size,
  input  logic [MEM_XLEN-1:0] i_wdata,
  input  logic [MEM_XLEN-1:0] i_rdata,
  output logic [MEM_XLEN-1:0] o_wdata,
  output logic [7:0]          o_strobe,
  output logic [MEM_XLEN-1:0] o_rdata
);

  mem_size_t           w_sz;
  logic [5:0]          w_bsh;
  logic [7:0]          w_mask;
  logic [MEM_XLEN-1:0] w_rsh;
  logic                w_sx;

  assign w_sz  = mem_size_t'(i_size[1:0]);
  assign w_bsh = {i_off, 3'b000};
  assign w_sx  = !i_size[2];

  // Lanes past byte 7 fall off the 8-bit shift.
  assign o_strobe = w_mask << i_off;
  assign o_wdata  = i_wdata << w_bsh;
  assign w_rsh    = i_rdata >> w_bsh;

  always_comb begin
    w_mask  = 8'hFF;
    o_rdata = w_rsh;
    unique case (1'b1)
      (w_sz == MSIZE_B): begin
        w_mask  = 8'h01;
        o_rdata = {{56{w_sx & w_rsh[7]}}, w_rsh[7:0]};
      end
      (w_sz == MSIZE_H): begin
        w_mask  = 8'h03;
        o_rdata = {{48{w_sx & w_rsh[15]}}, w_rsh[15:0]};
      end
      (w_sz == MSIZE_W): begin
        w_mask  = 8'h0F;
        o_rdata = {{32{w_sx & w_rsh[31]}}, w_rsh[31:0]};
      end
      default: begin
        w_mask  = 8'hFF;
        o_rdata = w_rsh;
      end
    endcase
  end

endmodule

// File: rtl/mem_forward_stage.sv
// Memory-stage slot: one bus request at a time, holds result, publishes fwd.
// Optional MEM_MISALIGN_CHECK_EN adds misalign_exc and suppresses bad requests.
module mem_forward_stage
  import mem_forward_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int BYTES = XLEN / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_regwrite,
  input  logic             in_memread,
  input  logic             in_memwrite,
  input  creg_addr_t       in_dst,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [2:0]       in_size,
  output logic             dreq_valid,
  output logic             dreq_write,
  output logic [XLEN-1:0]  dreq_addr,
  output logic [XLEN-1:0]  dreq_wdata,
  output logic [BYTES-1:0] dreq_strobe,
  input  logic             dresp_valid,
  input  logic [XLEN-1:0]  dresp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_regwrite,
  output creg_addr_t       out_dst,
  output logic [XLEN-1:0]  out_data,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic             misalign_exc,
`endif
  output forward_data_out  fwd,
  output logic             load_pending
);

  mem_state_t      r_state;
  mem_state_t      w_state_n;
  logic            r_regwrite;
  logic            r_memread;
  logic            r_memwrite;
  creg_addr_t      r_dst;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_data;
  logic [2:0]      r_size;
  logic            r_misalign;

  logic            w_accept;
  logic            w_mem_in;
  logic            w_bad_in;
  logic            w_busy;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_strobe;
  logic [XLEN-1:0] w_rdata;

  assign in_ready = !flush &&
    (r_state == IDLE || (r_state == DONE && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_mem_in = in_memread | in_memwrite;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_bad_in = w_mem_in &&
    misaligned(in_addr[2:0], in_size[1:0]);
  assign misalign_exc = (r_state == DONE) && r_misalign;
`else
  assign w_bad_in = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (flush)
          w_state_n = IDLE;
        else if (w_accept)
          w_state_n = (w_mem_in && !w_bad_in) ? REQ : DONE;
        else if (r_state == DONE && out_ready)
          w_state_n = IDLE;
      end
      REQ: begin
        if (dresp_valid)
          w_state_n = flush ? IDLE : DONE;
        else if (flush)
          w_state_n = DRAIN;
      end
      DRAIN: begin
        if (dresp_valid)
          w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  mem_lane_align u_lane (
    .i_off    (r_addr[2:0]),
    .i_size   (r_size),
    .i_wdata  (r_wdata),
    .i_rdata  (dresp_data),
    .o_wdata  (w_wdata),
    .o_strobe (w_strobe),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_dst      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_size     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_regwrite <= in_regwrite && !w_bad_in;
        r_memread  <= in_memread;
        r_memwrite <= in_memwrite;
        r_dst      <= in_dst;
        r_addr     <= in_addr;
        r_wdata    <= in_wdata;
        r_size     <= in_size;
        r_data     <= w_mem_in ? '0 : in_addr;
        r_misalign <= w_bad_in;
      end else if (w_state_n == IDLE) begin
        // Empty slot carries no stale data.
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_dst      <= '0;
        r_addr     <= '0;
        r_wdata    <= '0;
        r_data     <= '0;
        r_size     <= '0;
        r_misalign <= 1'b0;
      end else if (r_state == REQ && dresp_valid) begin
        r_data <= r_memread ? w_rdata : '0;
      end
    end
  end

  assign w_busy      = (r_state == REQ) || (r_state == DRAIN);
  assign dreq_valid  = w_busy;
  assign dreq_write  = w_busy && r_memwrite;
  assign dreq_addr   = w_busy ? {r_addr[XLEN-1:3], 3'b000} : '0;
  assign dreq_wdata  = w_busy ? w_wdata : '0;
  assign dreq_strobe = w_busy ? w_strobe : '0;

  assign out_valid    = (r_state == DONE);
  assign out_regwrite = r_regwrite;
  assign out_dst      = r_dst;
  assign out_data     = r_data;

  assign fwd.valid = (r_state == DONE) && r_regwrite && (r_dst != '0);
  assign fwd.dst   = r_dst;
  assign fwd.data  = r_data;

  assign load_pending = (r_state == REQ) && r_memread &&
    r_regwrite && (r_dst != '0);

endmodule

// File: tb/tb_mem_forward_stage.sv
// Directed bench for mem_forward_stage.
// Steps: reset, ALU op, load, store, flush, stall, dst=0, async reset.
module tb_mem_forward_stage;
  import mem_forward_stage_pkg::*;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_regwrite;
  logic            in_memread;
  logic            in_memwrite;
  creg_addr_t      in_dst;
  logic [63:0]     in_addr;
  logic [63:0]     in_wdata;
  logic [2:0]      in_size;
  logic            dreq_valid;
  logic            dreq_write;
  logic [63:0]     dreq_addr;
  logic [63:0]     dreq_wdata;
  logic [7:0]      dreq_strobe;
  logic            dresp_valid;
  logic [63:0]     dresp_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_regwrite;
  creg_addr_t      out_dst;
  logic [63:0]     out_data;
  forward_data_out fwd;
  logic            load_pending;

  int total;
  int bad;

  mem_forward_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_regwrite  (in_regwrite),
    .in_memread   (in_memread),
    .in_memwrite  (in_memwrite),
    .in_dst       (in_dst),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_size      (in_size),
    .dreq_valid   (dreq_valid),
    .dreq_write   (dreq_write),
    .dreq_addr    (dreq_addr),
    .dreq_wdata   (dreq_wdata),
    .dreq_strobe  (dreq_strobe),
    .dresp_valid  (dresp_valid),
    .dresp_data   (dresp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_regwrite (out_regwrite),
    .out_dst      (out_dst),
    .out_data     (out_data),
    .fwd          (fwd),
    .load_pending (load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic rw, input logic mr,
                    input logic mw, input logic [4:0] d,
                    input logic [63:0] a, input logic [63:0] wd,
                    input logic [2:0] sz);
    in_valid    = v;
    in_regwrite = rw;
    in_memread  = mr;
    in_memwrite = mw;
    in_dst      = d;
    in_addr     = a;
    in_wdata    = wd;
    in_size     = sz;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    flush = 1'b0;
    dresp_valid = 1'b0;
    dresp_data  = '0;
    out_ready   = 1'b1;
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_fwd", fwd, 0);
    chk("rst_load_pending", load_pending, 0);
    chk("rst_out_regwrite", out_regwrite, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_strobe", dreq_strobe, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU op, back-to-back second op
    op(1, 1, 0, 0, 5, 64'h1234, 0, 3);
    #1;
    chk("alu_in_ready0", in_ready, 1);
    tick();
    op(1, 1, 0, 0, 6, 64'h55, 0, 3);
    #1;
    chk("alu_out_valid", out_valid, 1);
    chk("alu_out_data", out_data, 64'h1234);
    chk("alu_fwd_valid", fwd.valid, 1);
    chk("alu_fwd_dst", fwd.dst, 5);
    chk("alu_fwd_data", fwd.data, 64'h1234);
    chk("alu_in_ready_b2b", in_ready, 1);
    chk("alu_no_req", dreq_valid, 0);
    tick();
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alu2_out_data", out_data, 64'h55);
    chk("alu2_fwd_dst", fwd.dst, 6);
    tick();
    chk("alu_idle_out_valid", out_valid, 0);
    chk("alu_idle_fwd_valid", fwd.valid, 0);

    // Signed byte load at 0x1003
    op(1, 1, 1, 0, 7, 64'h1003, 0, 3'd0);
    tick();
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lb_dreq_valid", dreq_valid, 1);
    chk("lb_dreq_addr", dreq_addr, 64'h1000);
    chk("lb_strobe", dreq_strobe, 8'h08);
    chk("lb_write", dreq_write, 0);
    chk("lb_load_pending", load_pending, 1);
    chk("lb_out_valid", out_valid, 0);
    chk("lb_fwd_valid", fwd.valid, 0);
    chk("lb_in_ready", in_ready, 0);
    tick();
    tick();
    chk("lb_hold_addr", dreq_addr, 64'h1000);
    chk("lb_hold_pending", load_pending, 1);
    dresp_valid = 1'b1;
    dresp_data  = 64'h00000000_80000000;
    tick();
    dresp_valid = 1'b0;
    dresp_data  = '0;
    #1;
    chk("lb_out_valid2", out_valid, 1);
    chk("lb_out_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_fwd_valid2", fwd.valid, 1);
    chk("lb_fwd_dst", fwd.dst, 7);
    chk("lb_pending_clr", load_pending, 0);
    chk("lb_dreq_clr", dreq_valid, 0);
    tick();

    // Store half at 0x2006
    op(1, 0, 0, 1, 8, 64'h2006, 64'hBEEF, 3'd1);
    tick();
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sh_wdata", dreq_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_strobe", dreq_strobe, 8'hC0);
    chk("sh_write", dreq_write, 1);
    chk("sh_addr", dreq_addr, 64'h2000);
    chk("sh_pending", load_pending, 0);
    dresp_valid = 1'b1;
    dresp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    dresp_valid = 1'b0;
    #1;
    chk("sh_out_valid", out_valid, 1);
    chk("sh_regwrite", out_regwrite, 0);
    chk("sh_fwd_valid", fwd.valid, 0);
    chk("sh_out_data", out_data, 0);
    tick();

    // Flush during REQ (unsigned word load at 0x3004)
    op(1, 1, 1, 0, 9, 64'h3004, 0, 3'd6);
    tick();
    op(1, 1, 0, 0, 11, 64'h99, 0, 3);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_drain_dreq", dreq_valid, 1);
    chk("fl_drain_addr", dreq_addr, 64'h3000);
    chk("fl_drain_strobe", dreq_strobe, 8'hF0);
    chk("fl_drain_out_valid", out_valid, 0);
    chk("fl_drain_in_ready", in_ready, 0);
    chk("fl_drain_pending", load_pending, 0);
    tick();
    chk("fl_drain_dreq2", dreq_valid, 1);
    dresp_valid = 1'b1;
    dresp_data  = 64'h1111_2222_3333_4444;
    tick();
    dresp_valid = 1'b0;
    #1;
    chk("fl_idle_dreq", dreq_valid, 0);
    chk("fl_idle_out_valid", out_valid, 0);
    chk("fl_idle_fwd", fwd.valid, 0);
    chk("fl_idle_in_ready", in_ready, 1);

    // Stall in DONE, then accept on release
    op(1, 1, 0, 0, 3, 64'hAA, 0, 3);
    out_ready = 1'b0;
    tick();
    op(1, 1, 0, 0, 4, 64'hBB, 0, 3);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_out_valid", out_valid, 1);
      chk("st_out_data", out_data, 64'hAA);
      chk("st_fwd_data", fwd.data, 64'hAA);
      chk("st_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("st_in_ready_rel", in_ready, 1);
    tick();
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("st_new_data", out_data, 64'hBB);
    chk("st_new_dst", fwd.dst, 4);
    chk("st_new_valid", out_valid, 1);
    tick();

    // Flush in DONE wins over in_valid
    op(1, 1, 0, 0, 2, 64'h77, 0, 3);
    out_ready = 1'b0;
    tick();
    op(1, 1, 0, 0, 12, 64'h66, 0, 3);
    flush = 1'b1;
    #1;
    chk("fd_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    op(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    #1;
    chk("fd_out_valid", out_valid, 0);
    chk("fd_fwd_valid", fwd.valid, 0);

    // dst=0 writes back but is never forwarded
    op(1, 1, 0, 0, 0, 64'h42, 0, 3);
    tick();
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("z_out_valid", out_valid, 1);
    chk("z_regwrite", out_regwrite, 1);
    chk("z_fwd_valid", fwd.valid, 0);
    tick();

    // Async reset in REQ
    op(1, 1, 1, 0, 10, 64'h4000, 0, 3'd3);
    tick();
    op(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_pre_dreq", dreq_valid, 1);
    chk("ar_pre_pending", load_pending, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_dreq", dreq_valid, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_fwd_valid", fwd.valid, 0);
    chk("ar_pending", load_pending, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("ar_idle_dreq", dreq_valid, 0);
    chk("ar_idle_out", out_valid, 0);
    chk("ar_idle_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
